// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: constants and types shared by the configuration loader.
//   CFG_BITS     - configuration bit count of the target FPGACore
//   load_state_e - loader state encoding (IDLE, RUN, LUTRST, DONE)
package fpga_cfg_pkg;

    localparam int unsigned CFG_BITS = 10080;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LUTRST = 2'd2,
        DONE   = 2'd3
    } load_state_e;

endpackage

// File: rtl/cfg_byte_shifter.sv
// cfg_byte_shifter: one-byte holding register feeding an 8-bit LSB-first
// shifter. Generates the registered byte-ready and bit-enable/data outputs.
//   clk, reset_n - clock, asynchronous active-low reset
//   run_next     - the loader will be in RUN after this edge; low flushes
//   room_next    - the byte budget still has room after this edge
//   in_valid     - byte offered
//   in_data      - offered byte
//   in_ready     - registered ready for the offered byte
//   accept       - handshake this cycle (in_valid && in_ready)
//   den          - registered bit enable
//   dta          - registered bit value, holds while den is low
module cfg_byte_shifter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_next,
    input  logic       room_next,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       accept,
    output logic       den,
    output logic       dta
);

    logic [7:0] hold_data, hold_data_n;
    logic       hold_full, hold_full_n;
    logic [7:0] sh_data, sh_data_n;
    logic [3:0] sh_cnt, sh_cnt_n;   // bits left, including the one on dta
    logic       in_ready_n, den_n, dta_n;

    assign accept = in_valid && in_ready;

    always_comb begin
        hold_data_n = hold_data;
        hold_full_n = hold_full;
        sh_data_n   = sh_data;
        sh_cnt_n    = sh_cnt;

        // Refill while the last bit is still on the wire so byte
        // boundaries carry no bubble.
        if (sh_cnt <= 4'd1 && hold_full) begin
            sh_data_n   = hold_data;
            sh_cnt_n    = 4'd8;
            hold_full_n = 1'b0;
        end else if (sh_cnt != 4'd0) begin
            sh_data_n = {1'b0, sh_data[7:1]};
            sh_cnt_n  = sh_cnt - 4'd1;
        end

        // Ready is only raised while the holding register is empty, so an
        // accept never collides with the refill above.
        if (accept) begin
            hold_data_n = in_data;
            hold_full_n = 1'b1;
        end

        // Leaving RUN (final bit, abort) drops any partial-byte leftovers.
        if (!run_next) begin
            hold_full_n = 1'b0;
            sh_cnt_n    = 4'd0;
        end

        in_ready_n = run_next && !hold_full_n && room_next;
        den_n      = run_next && (sh_cnt_n != 4'd0);
        dta_n      = den_n ? sh_data_n[0] : dta;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            sh_data   <= '0;
            sh_cnt    <= '0;
            in_ready  <= 1'b0;
            den       <= 1'b0;
            dta       <= 1'b0;
        end else begin
            hold_data <= hold_data_n;
            hold_full <= hold_full_n;
            sh_data   <= sh_data_n;
            sh_cnt    <= sh_cnt_n;
            in_ready  <= in_ready_n;
            den       <= den_n;
            dta       <= dta_n;
        end
    end

endmodule

// File: rtl/bitstream_loader.sv
// bitstream_loader: accepts a valid/ready byte stream and shifts it LSB-first
// into FPGACore's io_dta/io_den chain, then pulses the LUT reset and reports
// done.
//   BITS         - configuration bits per load
//   clk, reset_n - clock, asynchronous active-low reset
//   io_start     - begin a load (ignored while busy)
//   io_abort     - cancel a load in progress
//   io_in_valid / io_in_data / io_in_ready - byte stream handshake
//   io_dta, io_den - configuration bit and shift enable to the core
//   io_lut_reset - one-cycle LUT reset pulse to the core
//   io_busy      - load in progress
//   io_done      - sticky, last load completed
module bitstream_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned BITS = CFG_BITS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       io_start,
    input  logic       io_abort,
    input  logic       io_in_valid,
    input  logic [7:0] io_in_data,
    output logic       io_in_ready,
    output logic       io_dta,
    output logic       io_den,
    output logic       io_lut_reset,
    output logic       io_busy,
    output logic       io_done
);

    localparam int unsigned NBYTES = (BITS + 7) / 8;
    localparam int unsigned BCW    = $clog2(BITS + 1);
    localparam int unsigned YCW    = $clog2(NBYTES + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(BITS - 1);
    localparam logic [YCW-1:0] NBYTES_W = YCW'(NBYTES);

    load_state_e    state, state_n;
    logic [BCW-1:0] bit_cnt, bit_cnt_n;
    logic [YCW-1:0] byte_cnt, byte_cnt_n;
    logic           start_go, final_bit, run_next, room_next, accept;

    // A partial last byte needs no special case: the final-bit detect
    // leaves RUN and the shifter flush discards the unused upper bits.
    assign final_bit = io_den && (bit_cnt == LAST_BIT);

    always_comb begin
        state_n  = state;
        start_go = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (io_start && !io_abort) begin
                    state_n  = RUN;
                    start_go = 1'b1;
                end
            end
            RUN: begin
                if (io_abort)       state_n = IDLE;
                else if (final_bit) state_n = LUTRST;
            end
            LUTRST: state_n = io_abort ? IDLE : DONE;
        endcase

        bit_cnt_n  = start_go ? '0 : (io_den ? bit_cnt + 1'b1 : bit_cnt);
        byte_cnt_n = start_go ? '0 : byte_cnt + YCW'(accept);
        run_next   = (state_n == RUN);
        room_next  = (byte_cnt_n < NBYTES_W);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            io_busy      <= 1'b0;
            io_done      <= 1'b0;
            io_lut_reset <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            byte_cnt     <= byte_cnt_n;
            io_busy      <= (state_n == RUN) || (state_n == LUTRST);
            io_done      <= (state_n == DONE);
            io_lut_reset <= (state_n == LUTRST);
        end
    end

    cfg_byte_shifter u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .run_next  (run_next),
        .room_next (room_next),
        .in_valid  (io_in_valid),
        .in_data   (io_in_data),
        .in_ready  (io_in_ready),
        .accept    (accept),
        .den       (io_den),
        .dta       (io_dta)
    );

endmodule

// File: tb/tb_bitstream_loader.sv
module tb_bitstream_loader;

    localparam int unsigned FULL = fpga_cfg_pkg::CFG_BITS;
    localparam int unsigned NB   = (FULL + 7) / 8;

    logic       clk;
    logic       reset_n;
    logic       io_start, io_abort, io_in_valid;
    logic [7:0] io_in_data;
    logic       io_in_ready, io_dta, io_den, io_lut_reset, io_busy, io_done;

    logic       s_start, s_abort, s_valid;
    logic [7:0] s_data;
    logic       s_ready, s_dta, s_den, s_lut, s_busy, s_done;

    int checks = 0;
    int errors = 0;

    bitstream_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .io_start     (io_start),
        .io_abort     (io_abort),
        .io_in_valid  (io_in_valid),
        .io_in_data   (io_in_data),
        .io_in_ready  (io_in_ready),
        .io_dta       (io_dta),
        .io_den       (io_den),
        .io_lut_reset (io_lut_reset),
        .io_busy      (io_busy),
        .io_done      (io_done)
    );

    bitstream_loader #(.BITS(12)) dut12 (
        .clk          (clk),
        .reset_n      (reset_n),
        .io_start     (s_start),
        .io_abort     (s_abort),
        .io_in_valid  (s_valid),
        .io_in_data   (s_data),
        .io_in_ready  (s_ready),
        .io_dta       (s_dta),
        .io_den       (s_den),
        .io_lut_reset (s_lut),
        .io_busy      (s_busy),
        .io_done      (s_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard and per-load observations from drive_load.
    bit          exp_q[$];
    int unsigned r_den, r_runs, r_mism, r_lut, r_lut_bad, r_done_n, r_timeout;
    logic        r_done0, r_busy0, r_ready0;

    // Starts a load on dut, feeds bytes (gap idle cycles between bytes),
    // pops expected bits as io_den fires. Stops at done, at stop_bits
    // emitted bits (if nonzero), or on a cycle budget. Pulses io_start once
    // when pulse_bits bits have been emitted (if nonzero).
    task automatic drive_load(input int unsigned gap, input bit rnd,
                              input int unsigned stop_bits,
                              input int unsigned pulse_bits);
        int unsigned n, sent, cool;
        bit          pend, prev_den;
        exp_q.delete();
        r_den = 0; r_runs = 0; r_mism = 0; r_lut = 0; r_lut_bad = 0;
        r_done_n = 0; r_timeout = 0;
        sent = 0; cool = 0; pend = 0; prev_den = 0;
        @(negedge clk);
        io_start    = 1'b1;
        io_in_valid = 1'b0;
        @(negedge clk);
        io_start = 1'b0;
        r_done0  = io_done;
        r_busy0  = io_busy;
        r_ready0 = io_in_ready;
        n = 0;
        forever begin
            if (io_den) begin
                r_den++;
                if (!prev_den) r_runs++;
                if (exp_q.size() == 0) r_mism++;
                else if (io_dta !== exp_q.pop_front()) r_mism++;
            end
            if (io_lut_reset) begin
                r_lut++;
                if (!io_busy || io_den || !prev_den) r_lut_bad++;
            end
            prev_den = io_den;
            if (io_done) begin
                r_done_n = n;
                break;
            end
            if (stop_bits != 0 && r_den == stop_bits) break;
            if (n > 3 * FULL + 200) begin
                r_timeout = 1;
                break;
            end
            io_start = (pulse_bits != 0 && r_den == pulse_bits);
            if (!pend) begin
                if (cool != 0) cool--;
                else if (sent < NB) begin
                    pend       = 1'b1;
                    io_in_data = rnd ? 8'($urandom_range(0, 255)) : 8'hA5;
                end
            end
            io_in_valid = pend;
            if (pend && io_in_ready) begin
                for (int i = 0; i < 8; i++) exp_q.push_back(io_in_data[i]);
                sent++;
                pend = 1'b0;
                cool = gap;
            end
            @(negedge clk);
            n++;
        end
        io_start    = 1'b0;
        io_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({io_in_ready, io_dta, io_den, io_lut_reset, io_busy, io_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 000000",
                     {io_in_ready, io_dta, io_den, io_lut_reset, io_busy, io_done});
        end
        checks++;
        if ({s_ready, s_dta, s_den, s_lut, s_busy, s_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs_12 got %b expected 000000",
                     {s_ready, s_dta, s_den, s_lut, s_busy, s_done});
        end
        reset_n = 1'b1;
        drive_load(0, 1'b0, 3000, 0);
        checks++;
        if (r_den !== 3000 || {io_den, io_busy} !== 2'b11) begin
            errors++;
            $display("FAIL midload_before_reset got bits=%0d den/busy=%b expected 3000/11",
                     r_den, {io_den, io_busy});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({io_in_ready, io_dta, io_den, io_lut_reset, io_busy, io_done} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset got %b expected 000000",
                     {io_in_ready, io_dta, io_den, io_lut_reset, io_busy, io_done});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_full_load();
        drive_load(0, 1'b0, 0, 0);
        checks++;
        if (r_timeout !== 0) begin
            errors++;
            $display("FAIL full_timeout got %0d expected 0", r_timeout);
        end
        checks++;
        if ({r_busy0, r_ready0} !== 2'b11) begin
            errors++;
            $display("FAIL start_busy_ready got %b expected 11", {r_busy0, r_ready0});
        end
        checks++;
        if (r_den !== FULL || r_runs !== 1) begin
            errors++;
            $display("FAIL full_den got count=%0d runs=%0d expected %0d/1", r_den, r_runs, FULL);
        end
        checks++;
        if (r_mism !== 0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL full_a5_data got mism=%0d left=%0d expected 0/0", r_mism, exp_q.size());
        end
        checks++;
        if (r_lut !== 1 || r_lut_bad !== 0) begin
            errors++;
            $display("FAIL full_lut_pulse got n=%0d bad=%0d expected 1/0", r_lut, r_lut_bad);
        end
        checks++;
        if (r_done_n !== FULL + 3) begin
            errors++;
            $display("FAIL full_done_cycle got %0d expected %0d", r_done_n, FULL + 3);
        end
        checks++;
        if ({io_busy, io_in_ready, io_lut_reset, io_den} !== 4'b0) begin
            errors++;
            $display("FAIL full_after_done got %b expected 0000",
                     {io_busy, io_in_ready, io_lut_reset, io_den});
        end
    endtask

    task automatic test_gapped();
        checks++;
        if (io_done !== 1'b1) begin
            errors++;
            $display("FAIL done_sticky got %b expected 1", io_done);
        end
        drive_load(2, 1'b1, 0, 0);
        checks++;
        if (r_done0 !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_done got %b expected 0", r_done0);
        end
        checks++;
        if (r_timeout !== 0 || r_den !== FULL) begin
            errors++;
            $display("FAIL gapped_den got count=%0d timeout=%0d expected %0d/0", r_den, r_timeout, FULL);
        end
        checks++;
        if (r_mism !== 0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL gapped_data got mism=%0d left=%0d expected 0/0", r_mism, exp_q.size());
        end
        checks++;
        if (r_lut !== 1 || r_lut_bad !== 0) begin
            errors++;
            $display("FAIL gapped_lut_pulse got n=%0d bad=%0d expected 1/0", r_lut, r_lut_bad);
        end
    endtask

    task automatic test_abort();
        int unsigned lut_seen, busy_seen;
        drive_load(0, 1'b0, 500, 0);
        checks++;
        if (r_den !== 500 || io_den !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup got bits=%0d den=%b expected 500/1", r_den, io_den);
        end
        io_abort = 1'b1;
        @(negedge clk);
        io_abort = 1'b0;
        checks++;
        if ({io_den, io_busy, io_done, io_lut_reset, io_in_ready} !== 5'b0) begin
            errors++;
            $display("FAIL abort_outputs got %b expected 00000",
                     {io_den, io_busy, io_done, io_lut_reset, io_in_ready});
        end
        lut_seen = 0;
        busy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (io_lut_reset) lut_seen++;
            if (io_busy) busy_seen++;
        end
        checks++;
        if (lut_seen !== 0 || busy_seen !== 0) begin
            errors++;
            $display("FAIL abort_quiet got lut=%0d busy=%0d expected 0/0", lut_seen, busy_seen);
        end
    endtask

    task automatic test_start_abort_idle();
        int unsigned busy_seen;
        io_start = 1'b1;
        io_abort = 1'b1;
        @(negedge clk);
        io_start = 1'b0;
        io_abort = 1'b0;
        busy_seen = 0;
        repeat (3) begin
            if (io_busy || io_in_ready || io_den) busy_seen++;
            @(negedge clk);
        end
        checks++;
        if (busy_seen !== 0) begin
            errors++;
            $display("FAIL start_abort_idle got active_cycles=%0d expected 0", busy_seen);
        end
    endtask

    task automatic test_restart_pulse();
        drive_load(0, 1'b1, 0, 200);
        checks++;
        if (r_timeout !== 0 || r_den !== FULL || r_runs !== 1) begin
            errors++;
            $display("FAIL restart_den got count=%0d runs=%0d timeout=%0d expected %0d/1/0",
                     r_den, r_runs, r_timeout, FULL);
        end
        checks++;
        if (r_mism !== 0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL restart_data got mism=%0d left=%0d expected 0/0", r_mism, exp_q.size());
        end
        checks++;
        if (r_done_n !== FULL + 3 || r_lut !== 1) begin
            errors++;
            $display("FAIL restart_done got cycle=%0d lut=%0d expected %0d/1", r_done_n, r_lut, FULL + 3);
        end
    endtask

    task automatic test_bits12();
        bit          q12[$];
        logic [7:0]  b12[3];
        int unsigned den_n, mism, acc, late_ready, lut, done_n, pushed, idx;
        b12 = '{8'hFF, 8'h5A, 8'h00};
        den_n = 0; mism = 0; acc = 0; late_ready = 0; lut = 0; done_n = 0;
        pushed = 0; idx = 0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (s_den) begin
                den_n++;
                if (q12.size() == 0) mism++;
                else if (s_dta !== q12.pop_front()) mism++;
            end
            if (s_lut) lut++;
            if (acc >= 2 && s_ready) late_ready++;
            if (s_done && done_n == 0) done_n = n;
            s_valid = 1'b1;
            s_data  = b12[idx];
            if (s_ready) begin
                for (int i = 0; i < 8; i++) begin
                    if (pushed < 12) begin
                        q12.push_back(s_data[i]);
                        pushed++;
                    end
                end
                acc++;
                if (idx < 2) idx++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if (den_n !== 12 || mism !== 0 || q12.size() !== 0) begin
            errors++;
            $display("FAIL bits12_data got den=%0d mism=%0d left=%0d expected 12/0/0",
                     den_n, mism, q12.size());
        end
        checks++;
        if (acc !== 2 || late_ready !== 0) begin
            errors++;
            $display("FAIL bits12_surplus got accepted=%0d late_ready=%0d expected 2/0", acc, late_ready);
        end
        checks++;
        if (lut !== 1 || done_n !== 15 || s_done !== 1'b1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL bits12_done got lut=%0d done_at=%0d done=%b busy=%b expected 1/15/1/0",
                     lut, done_n, s_done, s_busy);
        end
    endtask

    initial begin
        clk         = 1'b0;
        reset_n     = 1'b0;
        io_start    = 1'b0;
        io_abort    = 1'b0;
        io_in_valid = 1'b0;
        io_in_data  = 8'h00;
        s_start     = 1'b0;
        s_abort     = 1'b0;
        s_valid     = 1'b0;
        s_data      = 8'h00;
        test_reset();
        test_full_load();
        test_gapped();
        test_abort();
        test_start_abort_idle();
        test_restart_pulse();
        test_bits12();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitstream_loader.md
# bitstream_loader

Byte-wide front end for FPGA configuration. Sits directly upstream of `FPGACore`. Accepts the configuration bitstream as a valid/ready byte stream and serialises it LSB-first onto the core's `io_dta`/`io_den` shift-register interface. After the last bit it pulses the core's LUT reset (`io_reset`) for one cycle and then reports done. This replaces hand-clocked bit loading with a hardware block that a UART/SPI receiver can drive.

## Interface
- `BITS`, default 10080: total configuration bits to shift into the core.
- `NBYTES`, default ceil(BITS/8): bytes consumed per load. Derived; not overridable.
- `clk`  in  1: single clock. All logic is on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `io_start`  in  1: one-cycle pulse that begins a load. Ignored while busy.
- `io_abort`  in  1: cancels a load in progress.
- `io_in_valid`  in  1: a byte is offered.
- `io_in_data`  in  8: the offered byte. Bit 0 is shifted first.
- `io_in_ready`  out  1: the loader accepts the byte this cycle.
- `io_dta`  out  1: configuration data bit. Connects to core `io_dta`.
- `io_den`  out  1: data enable. The core shifts `io_dta` on each `clk` edge while this is high.
- `io_lut_reset`  out  1: connects to core `io_reset`.
- `io_busy`  out  1: a load is in progress.
- `io_done`  out  1: sticky. The last load completed.

## Operation
- States: IDLE, RUN, LUTRST, DONE. DONE behaves like IDLE but holds `io_done`=1.
- Transitions:
  - IDLE/DONE + `io_start` -> RUN. Counters clear and `io_done` clears.
  - RUN + final bit emitted -> LUTRST.
  - LUTRST -> DONE after exactly one cycle.
  - RUN/LUTRST + `io_abort` -> IDLE. `io_abort` has priority over everything else in the same cycle.
- Datapath: a one-byte holding register feeds an 8-bit shifter.
  - `io_in_ready` = RUN && holding empty && bytes_accepted < NBYTES.
  - A handshake (`io_in_valid` && `io_in_ready`) loads the holding register.
  - When the shifter is empty or emitting its last bit, the holding register moves into the shifter on that same edge. This gives no bubbles at byte boundaries.
- Emission: every RUN cycle with a bit available drives `io_den`=1 and `io_dta`=current shifter LSB.
- Starvation: no bit available means `io_den`=0. `io_dta` then holds its last value, and the core does not shift.
- Bit counter: width $clog2(BITS+1). It increments on each `io_den`=1 cycle. The final bit is the one at count BITS-1.
- Partial last byte: if BITS%8 != 0, only the low BITS%8 bits of the last byte are emitted. The upper bits are discarded.
- Surplus bytes: after NBYTES are accepted, `io_in_ready` stays 0. Surplus offered bytes are neither consumed nor acknowledged.
- Abort:
  - `io_den`, `io_lut_reset`, `io_busy` and `io_done` go to 0 on the next edge.
  - The holding register and shifter are flushed.
  - `io_lut_reset` is not pulsed.
- `io_start` during RUN/LUTRST: ignored, with no side effects.
- `io_start` and `io_abort` together in IDLE: the loader stays in IDLE.

## Timing
- All outputs are registered.
- Reset values: `io_in_ready`, `io_dta`, `io_den`, `io_lut_reset`, `io_busy` and `io_done` are all 0; state is IDLE. Reset asserts asynchronously, at any point mid-load, and releases on the next `clk` edge.
- `io_start` accepted at edge t -> `io_busy`=1 and `io_in_ready`=1 from edge t.
- Byte accepted at edge k with the shifter idle -> its bit 0 appears with `io_den`=1 after edge k+1.
- Continuous valid: `io_den` stays high for exactly BITS consecutive cycles.
- End of load:
  - Cycle after the final `io_den`=1: `io_den`=0 and `io_lut_reset`=1 for exactly one cycle. `io_busy` stays 1.
  - Following cycle: `io_lut_reset`=0, `io_busy`=0, `io_done`=1.
- Minimum load time with continuous valid: BITS+3 cycles from `io_start`.

## Structure
- Shared package `fpga_cfg_pkg` holds:
  - constant `CFG_BITS`=10080, used as the default for `BITS`;
  - the loader state enum (IDLE, RUN, LUTRST, DONE).
- Sub-module `cfg_byte_shifter` contains the holding register, the 8-bit shifter, the valid-bit counter, and ready/den generation. The parent module holds the FSM and the bit/byte counters.

## Test plan
- Reset: hold `reset_n`=0 -> all outputs 0. Assert `reset_n` low asynchronously mid-load (at bit 3000) -> outputs go 0 immediately; a new `io_start` then completes normally.
- Full load, BITS=10080, 1260 bytes of 0xA5 with valid held high:
  - `io_den` is high for 10080 contiguous cycles;
  - `io_dta` repeats 1,0,1,0,0,1,0,1 per byte;
  - one `io_lut_reset` pulse, then `io_done`=1 at cycle 10083.
- Gapped input, valid every 3rd cycle with random bytes: the `io_den`-high count is exactly 10080, and the captured `io_dta` sequence equals the LSB-first concatenation of the bytes.
- BITS=12, bytes 0xFF then 0x5A:
  - emitted bits are 1 ×8 followed by 0,1,0,1;
  - `io_in_ready` stays 0 after the second byte, with a third 0x00 byte offered and not consumed;
  - `io_done`=1.
- Abort after bit 500:
  - next cycle `io_den`=0, `io_busy`=0, `io_done`=0, no `io_lut_reset`;
  - a restart delivers the full 10080 bits.
- Control corner cases:
  - `io_start` pulsed at bit 200 is ignored and the count is unaffected;
  - `io_start` with `io_abort` in IDLE stays in IDLE;
  - `io_start` from DONE clears `io_done` on the same edge.
